// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with prescaler, wrap or saturate at the bounds,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module mod_updown_counter #(
  parameter int     WIDTH    = 8,
  parameter longint MODULO   = 64'd1 << WIDTH,
  parameter int     DIV      = 1,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
  localparam logic [15:0]      LP_LAST = 16'(DIV - 1);
  localparam logic [15:0]      LP_P1   = 16'd1;

  logic [WIDTH-1:0] r_count;
  logic [15:0]      r_pre;
  logic             r_tc;
  logic             r_ovf;

  logic             w_last;
  logic             w_step;
  logic             w_bound;
  logic             w_evt;
  logic [WIDTH-1:0] w_wrap;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;
  logic [15:0]      w_pre_nxt;

  always_comb begin
    w_last  = (r_pre == LP_LAST);
    w_step  = en & ~load & w_last;
    w_bound = dir ? (r_count == LP_MAX)
                  : (r_count == '0);
    w_evt   = w_step & w_bound;
    w_wrap  = dir ? '0 : LP_MAX;
    // Saturation holds the boundary value; wrap jumps to the other end.
    if (w_bound)
      w_step_val = SATURATE ? r_count : w_wrap;
    else if (dir)
      w_step_val = r_count + LP_ONE;
    else
      w_step_val = r_count - LP_ONE;
    w_load_val = (load_val > LP_MAX) ? LP_MAX
                                     : load_val;
    w_pre_nxt = r_pre;
    if (load)
      w_pre_nxt = '0;
    else if (en)
      w_pre_nxt = w_last ? '0 : r_pre + LP_P1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pre <= w_pre_nxt;
      r_tc  <= w_evt;
      if (load)
        r_count <= w_load_val;
      else if (w_step)
        r_count <= w_step_val;
      if (w_evt)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count register width (2..32).
REQ-002 SHALL have parameter MODULO, default 2**WIDTH, count range 0..MODULO-1 (2..2**WIDTH).
REQ-003 SHALL have parameter DIV, default 1, enabled cycles per count step (1..65535).
REQ-004 SHALL have parameter SATURATE, default 0, boundary mode: 0 = wrap, 1 = hold at boundary.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port en  input  1  count enable; prescaler advances only when high.
REQ-008 SHALL have port dir  input  1  direction: 1 = up, 0 = down; sampled at each step.
REQ-009 SHALL have port load  input  1  synchronous load of load_val.
REQ-010 SHALL have port load_val  input  WIDTH  load value.
REQ-011 SHALL have port clr_ovf  input  1  clears sticky ovf.
REQ-012 SHALL have port count  output  WIDTH  registered count value.
REQ-013 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 SHALL have port ovf  output  1  sticky flag: a boundary crossing or hit occurred.

Function
REQ-015 SHALL use priority per cycle: rst > load > step > hold.
REQ-016 SHALL keep an internal prescaler 0..DIV-1 that increments on each cycle with en=1 and no load; a step occurs when the prescaler is DIV-1 and en=1, and the prescaler then returns to 0.
REQ-017 SHALL leave the prescaler and count unchanged when en=0.
REQ-018 SHALL, on load=1, set count to min(load_val, MODULO-1) and clear the prescaler on the next edge; tc=0 that cycle; en is ignored.
REQ-019 SHALL, on an up step with count < MODULO-1, set count to count+1; on a down step with count > 0, set count to count-1.
REQ-020 SHALL, on an up step at MODULO-1: with SATURATE=0, set count to 0; with SATURATE=1, hold MODULO-1.
REQ-021 SHALL, on a down step at 0: with SATURATE=0, set count to MODULO-1; with SATURATE=1, hold 0.
REQ-022 SHALL assert tc for exactly the one cycle following any step taken at a boundary per REQ-020/021; a step at a boundary is a boundary event.
REQ-023 SHALL keep tc high on consecutive cycles when consecutive steps are boundary events, e.g. saturated with DIV=1.
REQ-024 SHALL set ovf on every boundary event and hold it until clr_ovf=1 or rst=1.
REQ-025 SHALL give set priority over clr_ovf when a boundary event and clr_ovf=1 occur in the same cycle.
REQ-026 SHALL use latency of one clock from the qualifying input edge to the count/tc/ovf update; all outputs are registered, with no combinational input-to-output path.
REQ-027 SHALL perform all arithmetic in WIDTH bits; when MODULO=2**WIDTH, wrap is natural overflow and no value >= MODULO is ever reachable.
REQ-028 SHALL take effect at the next step when dir changes between steps; the prescaler is not reset by dir changes.

Reset
REQ-029 SHALL, while rst=1 at a rising edge, set count=0, tc=0, ovf=0 and prescaler=0, overriding load, en and clr_ovf.
REQ-030 SHALL, when rst is asserted mid-operation or mid-prescale, discard the partial prescale; counting resumes from 0 with a full DIV-cycle interval after rst deasserts.
REQ-031 SHALL make no output depend on initial register values after the first reset edge.

Verification
REQ-032 SHALL cover: WIDTH=8, MODULO=200, DIV=1, SATURATE=0; rst 2 cycles, then en=1, dir=1 for 200 cycles -> count runs 0..199, returns to 0; tc high one cycle with count=0; ovf=1.
REQ-033 SHALL cover, same config: load=1, load_val=250 -> count=199 next cycle; then dir=0 for 200 steps -> reaches 0, then 199; tc pulses once.
REQ-034 SHALL cover: SATURATE=1, MODULO=200, load 198, en=1, dir=1 for 4 cycles -> count 199,199,199,199; tc high 3 consecutive cycles; ovf=1; clr_ovf while saturated stepping -> ovf stays 1.
REQ-035 SHALL cover: DIV=4, MODULO=256, en=1 from reset -> count increments on every 4th enabled cycle; en dropped for 3 cycles mid-interval -> step delayed exactly 3 cycles.
REQ-036 SHALL cover: DIV=4, rst asserted 2 cycles into a prescale interval with count=10 -> count=0, ovf=0; first step occurs 4 enabled cycles after rst deasserts.
REQ-037 SHALL cover: load=1 and en=1 with count=199 and dir=1 in the same cycle -> count=load_val, tc=0, ovf unchanged.
